sm3_cmprss_core_mr: RTL and testbench

- Parametrised successor to the single-round SM3 compression core.
- Performs RND_PER_CYC SM3 rounds per clock with full valid/ready handshaking on both sides.
- Chains multi-block messages internally: V(i+1) = CF(V(i), B(i)).
- Sits between the SM3 message-expansion stage (upstream, supplies Wj/W'j lanes) and the digest/output stage (downstream).

---
 rtl/sm3_cmprss_core_mr.sv | 146 ++++++++++++++
 tb/tb_sm3_cmprss_core_mr.sv | 405 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sm3_cmprss_core_mr.sv
// SM3 compression core running RND_PER_CYC rounds per clock, chaining blocks internally.
// Optional macro SM3_CMPRSS_MID_DGST_EN emits every intermediate chaining value with a last flag.
module sm3_cmprss_core_mr #(
  parameter int RND_PER_CYC = 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [32*RND_PER_CYC-1:0]  expnd_inpt_wj_i,
  input  logic [32*RND_PER_CYC-1:0]  expnd_inpt_wjj_i,
  input  logic                       expnd_inpt_lst_i,
  input  logic                       expnd_inpt_vld_i,
  output logic                       expnd_inpt_rdy_o,
  output logic [255:0]               cmprss_otpt_res_o,
  output logic                       cmprss_otpt_vld_o,
  input  logic                       cmprss_otpt_rdy_i,
`ifdef SM3_CMPRSS_MID_DGST_EN
  output logic                       cmprss_otpt_lst_o,
`endif
  output logic                       cmprss_busy_o
);

  localparam int BEATS_PER_BLK = 64 / RND_PER_CYC;
  localparam int CNT_W         = $clog2(BEATS_PER_BLK);

  localparam logic [255:0] IV = 256'h7380166f_4914b2b9_172442d7_da8a0600_a96f30bc_163138aa_e38dee4d_b0fb0e4e;
  localparam logic [31:0]  T_LO = 32'h79cc4519;
  localparam logic [31:0]  T_HI = 32'h7a879d8a;

  localparam logic [1:0] RUN  = 2'd0;
  localparam logic [1:0] FOLD = 2'd1;
  localparam logic [1:0] OUT  = 2'd2;

  if (RND_PER_CYC != 1 && RND_PER_CYC != 2 && RND_PER_CYC != 4 && RND_PER_CYC != 8) begin : g_rpc_chk
    $error("sm3_cmprss_core_mr: RND_PER_CYC must be 1, 2, 4 or 8");
  end

  logic [1:0]       state;
  logic [CNT_W-1:0] beat_cnt;
  logic [255:0]     v;
  logic [255:0]     abcd;
  logic [255:0]     rnd_nxt;
  logic             lst_q;

  function automatic logic [31:0] rotl(input logic [31:0] x, input logic [4:0] n);
    logic [63:0] d;
    d = {x, x} << n;
    return d[63:32];
  endfunction

  function automatic logic [31:0] p0(input logic [31:0] x);
    return x ^ rotl(x, 5'd9) ^ rotl(x, 5'd17);
  endfunction

  // One SM3 round; state packed A..H from MSB to LSB, same as the digest layout.
  function automatic logic [255:0] sm3_round(input logic [255:0] s, input logic [5:0] j,
                                             input logic [31:0] w, input logic [31:0] wp);
    logic [31:0] a, b, c, d, e, f, g, h;
    logic [31:0] tj, a12, ss1, ss2, ff, gg, tt1, tt2;
    {a, b, c, d, e, f, g, h} = s;
    tj  = (j < 6'd16) ? T_LO : T_HI;
    a12 = rotl(a, 5'd12);
    ss1 = rotl(a12 + e + rotl(tj, j[4:0]), 5'd7);
    ss2 = ss1 ^ a12;
    if (j < 6'd16) begin
      ff = a ^ b ^ c;
      gg = e ^ f ^ g;
    end else begin
      ff = (a & b) | (a & c) | (b & c);
      gg = (e & f) | (~e & g);
    end
    tt1 = ff + d + ss2 + wp;
    tt2 = gg + h + ss1 + w;
    return {tt1, a, rotl(b, 5'd9), c, p0(tt2), e, rotl(f, 5'd19), g};
  endfunction

  // NOTE: rnd_nxt is a combinational chain, so it is defaulted first and updated
  // with blocking assignments; each lane sees the previous lane's result.
  always_comb begin
    rnd_nxt = abcd;
    for (int k = 0; k < RND_PER_CYC; k++) begin
      rnd_nxt = sm3_round(rnd_nxt, 6'(int'(beat_cnt) * RND_PER_CYC + k),
                          expnd_inpt_wj_i[32*k +: 32], expnd_inpt_wjj_i[32*k +: 32]);
    end
  end

  // NOTE: all state is registered with non-blocking assignments so every register
  // samples pre-edge values; the round datapath and V are reset to IV, not zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= RUN;
      beat_cnt <= '0;
      v        <= IV;
      abcd     <= IV;
      lst_q    <= 1'b0;
    end else begin
      case (state)
        RUN: begin
          if (expnd_inpt_vld_i) begin
            abcd <= rnd_nxt;
            if (beat_cnt == CNT_W'(BEATS_PER_BLK - 1)) begin
              beat_cnt <= '0;
              lst_q    <= expnd_inpt_lst_i;
              state    <= FOLD;
            end else begin
              beat_cnt <= beat_cnt + CNT_W'(1);
            end
          end
        end
        FOLD: begin
          v    <= v ^ abcd;
          abcd <= v ^ abcd;
`ifdef SM3_CMPRSS_MID_DGST_EN
          state <= OUT;
`else
          state <= lst_q ? OUT : RUN;
`endif
        end
        OUT: begin
          if (cmprss_otpt_rdy_i) begin
`ifdef SM3_CMPRSS_MID_DGST_EN
            // Intermediate values keep chaining; only a final digest restarts from IV.
            if (lst_q) begin
              v    <= IV;
              abcd <= IV;
            end
`else
            v    <= IV;
            abcd <= IV;
`endif
            state <= RUN;
          end
        end
        default: state <= RUN;
      endcase
    end
  end

  assign expnd_inpt_rdy_o  = (state == RUN);
  assign cmprss_otpt_vld_o = (state == OUT);
  assign cmprss_otpt_res_o = cmprss_otpt_vld_o ? v : '0;
  assign cmprss_busy_o     = (beat_cnt != '0) || (state != RUN);
`ifdef SM3_CMPRSS_MID_DGST_EN
  assign cmprss_otpt_lst_o = cmprss_otpt_vld_o & lst_q;
`endif

endmodule

// File: tb/tb_sm3_cmprss_core_mr.sv
// Directed bench for sm3_cmprss_core_mr: four instances (1/2/4/8 rounds per cycle) fed from one
// message-expansion model; digests are checked against published SM3 reference values.
module tb_sm3_cmprss_core_mr;

  localparam logic [255:0] IV      = 256'h7380166f_4914b2b9_172442d7_da8a0600_a96f30bc_163138aa_e38dee4d_b0fb0e4e;
  localparam logic [255:0] ABC_DG  = 256'h66c7f0f4_62eeedd9_d1f2d46b_dc10e4e2_4167c487_5cf2f7a2_297da02b_8f4ba8e0;
  localparam logic [255:0] ABCD_DG = 256'hdebe9ff9_2275b8a1_38604889_c18e5a4d_6fdb70e5_387e5765_293dcba3_9c0c5732;
  localparam logic [511:0] ABC_BLK   = {32'h61626380, 448'h0, 32'h00000018};
  localparam logic [511:0] ABCD_BLK0 = {16{32'h61626364}};
  localparam logic [511:0] ABCD_BLK1 = {32'h80000000, 448'h0, 32'h00000200};
`ifdef SM3_CMPRSS_MID_DGST_EN
  localparam int OUTS_2BLK = 2;
`else
  localparam int OUTS_2BLK = 1;
`endif

  logic clk;
  logic rst;
  logic vld;
  logic lst_in;
  logic rdy_i;
  int   sel;
  int   rpc;
  int   j0;
  int   checks;
  int   errors;
  int   hs_cnt = 0;

  logic [31:0]  w_arr [68];
  logic [31:0]  wp_arr[64];
  logic         rdy_v [4];
  logic         vld_v [4];
  logic         busy_v[4];
  logic         lst_v [4];
  logic [255:0] res_v [4];

  logic         cur_rdy;
  logic         cur_vld;
  logic         cur_busy;
  logic         cur_lst;
  logic [255:0] cur_res;

  assign cur_rdy  = rdy_v[sel];
  assign cur_vld  = vld_v[sel];
  assign cur_busy = busy_v[sel];
  assign cur_res  = res_v[sel];
  assign cur_lst  = lst_v[sel];

  for (genvar gi = 0; gi < 4; gi++) begin : g_dut
    localparam int R = 1 << gi;
    logic [32*R-1:0] wj;
    logic [32*R-1:0] wjj;
    logic            dvld;
    for (genvar k = 0; k < R; k++) begin : g_lane
      assign wj[32*k +: 32]  = w_arr[(j0 + k) & 63];
      assign wjj[32*k +: 32] = wp_arr[(j0 + k) & 63];
    end
    assign dvld = vld && (sel == gi);
`ifndef SM3_CMPRSS_MID_DGST_EN
    assign lst_v[gi] = 1'b0;
`endif
    sm3_cmprss_core_mr #(.RND_PER_CYC(R)) u_dut (
      .clk               (clk),
      .rst               (rst),
      .expnd_inpt_wj_i   (wj),
      .expnd_inpt_wjj_i  (wjj),
      .expnd_inpt_lst_i  (lst_in),
      .expnd_inpt_vld_i  (dvld),
      .expnd_inpt_rdy_o  (rdy_v[gi]),
      .cmprss_otpt_res_o (res_v[gi]),
      .cmprss_otpt_vld_o (vld_v[gi]),
      .cmprss_otpt_rdy_i (rdy_i),
`ifdef SM3_CMPRSS_MID_DGST_EN
      .cmprss_otpt_lst_o (lst_v[gi]),
`endif
      .cmprss_busy_o     (busy_v[gi])
    );
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (!rst && cur_vld && rdy_i) hs_cnt <= hs_cnt + 1;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog expired");
  end

  function automatic logic [31:0] rl(input logic [31:0] x, input int n);
    return (x << n) | (x >> (32 - n));
  endfunction

  // Standard SM3 message expansion of one padded 512-bit block.
  task automatic expand(input logic [511:0] blk);
    logic [31:0] x;
    for (int i = 0; i < 16; i++) w_arr[i] = blk[511 - 32*i -: 32];
    for (int i = 16; i < 68; i++) begin
      x = w_arr[i-16] ^ w_arr[i-9] ^ rl(w_arr[i-3], 15);
      w_arr[i] = x ^ rl(x, 15) ^ rl(x, 23) ^ rl(w_arr[i-13], 7) ^ w_arr[i-6];
    end
    for (int i = 0; i < 64; i++) wp_arr[i] = w_arr[i] ^ w_arr[i+4];
  endtask

  task automatic select(input int s);
    sel = s;
    rpc = 1 << s;
  endtask

  // Called at a negedge; returns at the negedge after the last beat was accepted.
  task automatic send_block(input logic [511:0] blk, input logic lst, input int gap_pct,
                            input int early_beat, input int n_beats);
    int beats;
    int guard;
    beats = (n_beats > 0) ? n_beats : 64 / rpc;
    expand(blk);
    for (int b = 0; b < beats; b++) begin
      while (gap_pct > 0 && $urandom_range(99) < gap_pct) begin
        vld = 1'b0;
        @(negedge clk);
      end
      j0     = b * rpc;
      lst_in = (b == 64 / rpc - 1) ? lst : (b == early_beat);
      vld    = 1'b1;
      guard  = 0;
      while (!cur_rdy && guard < 200) begin
        @(negedge clk);
        guard++;
      end
      if (!cur_rdy) begin
        checks++;
        errors++;
        $display("FAIL beat_accept: rdy_o stayed 0 for %0d cycles, required 1", guard);
        vld    = 1'b0;
        lst_in = 1'b0;
        return;
      end
      @(negedge clk);
    end
    vld    = 1'b0;
    lst_in = 1'b0;
  endtask

  // Waits (bounded) for vld, captures the output, and lets the handshake complete (rdy_i high).
  task automatic get_digest(output logic [255:0] dg, output logic lst_o);
    int guard;
    guard = 0;
    dg    = '0;
    lst_o = 1'b0;
    while (!cur_vld && guard < 300) begin
      @(negedge clk);
      guard++;
    end
    checks++;
    if (!cur_vld) begin
      errors++;
      $display("FAIL digest_wait: vld stayed 0 for %0d cycles, required 1", guard);
    end else begin
      dg    = cur_res;
      lst_o = cur_lst;
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (rdy_v[i] !== 1'b1 || vld_v[i] !== 1'b0 || busy_v[i] !== 1'b0 || res_v[i] !== '0) begin
        errors++;
        $display("FAIL reset_state[%0d]: got rdy=%b vld=%b busy=%b res=%h required rdy=1 vld=0 busy=0 res=0",
                 i, rdy_v[i], vld_v[i], busy_v[i], res_v[i]);
      end
    end
  endtask

  task automatic test_abc_latency();
    select(0);
    send_block(ABC_BLK, 1'b1, 0, -1, 0);
    checks++;
    if (cur_vld !== 1'b0 || cur_busy !== 1'b1 || cur_rdy !== 1'b0) begin
      errors++;
      $display("FAIL abc_fold_cycle: got vld=%b busy=%b rdy=%b required vld=0 busy=1 rdy=0", cur_vld, cur_busy, cur_rdy);
    end
    @(negedge clk);
    checks++;
    if (cur_vld !== 1'b1) begin
      errors++;
      $display("FAIL abc_latency: got vld=%b two edges after last beat, required 1", cur_vld);
    end
    checks++;
    if (cur_res !== ABC_DG) begin
      errors++;
      $display("FAIL abc_digest: got %h required %h", cur_res, ABC_DG);
    end
    @(negedge clk);
    checks++;
    if (cur_vld !== 1'b0 || cur_rdy !== 1'b1 || cur_busy !== 1'b0) begin
      errors++;
      $display("FAIL abc_after_out: got vld=%b rdy=%b busy=%b required vld=0 rdy=1 busy=0", cur_vld, cur_rdy, cur_busy);
    end
  endtask

  task automatic test_two_block_rpc();
    logic [255:0] dg;
    logic         l;
    int           h0;
    for (int s = 0; s < 4; s++) begin
      select(s);
      h0 = hs_cnt;
      send_block(ABCD_BLK0, 1'b0, 0, -1, 0);
      send_block(ABCD_BLK1, 1'b1, 0, -1, 0);
      get_digest(dg, l);
      checks++;
      if (dg !== ABCD_DG) begin
        errors++;
        $display("FAIL two_block_digest_rpc%0d: got %h required %h", rpc, dg, ABCD_DG);
      end
      checks++;
      if (hs_cnt - h0 != OUTS_2BLK) begin
        errors++;
        $display("FAIL two_block_pulses_rpc%0d: got %0d output handshakes required %0d", rpc, hs_cnt - h0, OUTS_2BLK);
      end
    end
  endtask

  task automatic test_backpressure();
    logic [255:0] r0;
    int           guard;
    select(0);
    rdy_i = 1'b0;
    send_block(ABC_BLK, 1'b1, 0, -1, 0);
    guard = 0;
    while (!cur_vld && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    r0 = cur_res;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      checks++;
      if (cur_vld !== 1'b1 || cur_res !== r0 || cur_rdy !== 1'b0) begin
        errors++;
        $display("FAIL stall_hold_cycle%0d: got vld=%b rdy=%b res=%h required vld=1 rdy=0 res=%h",
                 c, cur_vld, cur_rdy, cur_res, r0);
      end
    end
    checks++;
    if (r0 !== ABC_DG) begin
      errors++;
      $display("FAIL stall_digest: got %h required %h", r0, ABC_DG);
    end
    rdy_i = 1'b1;
    @(negedge clk);
    checks++;
    if (cur_vld !== 1'b0 || cur_rdy !== 1'b1) begin
      errors++;
      $display("FAIL stall_release: got vld=%b rdy=%b required vld=0 rdy=1", cur_vld, cur_rdy);
    end
  endtask

  task automatic test_input_gaps();
    logic [255:0] dg;
    logic         l;
    select(0);
    send_block(ABC_BLK, 1'b1, 50, -1, 0);
    get_digest(dg, l);
    checks++;
    if (dg !== ABC_DG) begin
      errors++;
      $display("FAIL gaps_abc_digest: got %h required %h", dg, ABC_DG);
    end
    select(1);
    send_block(ABCD_BLK0, 1'b0, 40, -1, 0);
    send_block(ABCD_BLK1, 1'b1, 40, -1, 0);
    get_digest(dg, l);
    checks++;
    if (dg !== ABCD_DG) begin
      errors++;
      $display("FAIL gaps_two_block_digest: got %h required %h", dg, ABCD_DG);
    end
  endtask

  task automatic test_back_to_back();
    logic [255:0] d1;
    logic [255:0] d2;
    logic         l;
    select(0);
    send_block(ABC_BLK, 1'b1, 0, -1, 0);
    get_digest(d1, l);
    send_block(ABC_BLK, 1'b1, 0, -1, 0);
    get_digest(d2, l);
    checks++;
    if (d1 !== ABC_DG) begin
      errors++;
      $display("FAIL b2b_first_digest: got %h required %h", d1, ABC_DG);
    end
    checks++;
    if (d2 !== ABC_DG) begin
      errors++;
      $display("FAIL b2b_second_digest: got %h required %h", d2, ABC_DG);
    end
  endtask

  task automatic test_lst_non_final();
    logic [255:0] dg;
    logic         l;
    int           h0;
    select(0);
    h0 = hs_cnt;
    send_block(ABCD_BLK0, 1'b0, 0, 10, 0);
    send_block(ABCD_BLK1, 1'b1, 0, -1, 0);
    get_digest(dg, l);
    checks++;
    if (dg !== ABCD_DG) begin
      errors++;
      $display("FAIL early_lst_digest: got %h required %h", dg, ABCD_DG);
    end
    checks++;
    if (hs_cnt - h0 != OUTS_2BLK) begin
      errors++;
      $display("FAIL early_lst_pulses: got %0d output handshakes required %0d", hs_cnt - h0, OUTS_2BLK);
    end
  endtask

  task automatic test_mid_reset();
    logic [255:0] dg;
    logic         l;
    select(0);
    send_block(ABC_BLK, 1'b0, 0, -1, 20);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++;
    if (cur_rdy !== 1'b1 || cur_vld !== 1'b0 || cur_busy !== 1'b0 || cur_res !== '0) begin
      errors++;
      $display("FAIL mid_reset_state: got rdy=%b vld=%b busy=%b res=%h required rdy=1 vld=0 busy=0 res=0",
               cur_rdy, cur_vld, cur_busy, cur_res);
    end
    send_block(ABC_BLK, 1'b1, 0, -1, 0);
    get_digest(dg, l);
    checks++;
    if (dg !== ABC_DG) begin
      errors++;
      $display("FAIL mid_reset_digest: got %h required %h", dg, ABC_DG);
    end
  endtask

`ifdef SM3_CMPRSS_MID_DGST_EN
  task automatic test_mid_dgst();
    logic [255:0] d1;
    logic [255:0] d2;
    logic         l1;
    logic         l2;
    select(0);
    send_block(ABCD_BLK0, 1'b0, 0, -1, 0);
    get_digest(d1, l1);
    send_block(ABCD_BLK1, 1'b1, 0, -1, 0);
    get_digest(d2, l2);
    checks++;
    if (l1 !== 1'b0 || d1 === IV || d1 === ABCD_DG) begin
      errors++;
      $display("FAIL mid_dgst_first: got lst=%b res=%h required lst=0 and an intermediate value", l1, d1);
    end
    checks++;
    if (l2 !== 1'b1 || d2 !== ABCD_DG) begin
      errors++;
      $display("FAIL mid_dgst_final: got lst=%b res=%h required lst=1 res=%h", l2, d2, ABCD_DG);
    end
  endtask
`endif

  initial begin
    checks = 0;
    errors = 0;
    rst    = 1'b1;
    vld    = 1'b0;
    lst_in = 1'b0;
    rdy_i  = 1'b1;
    j0     = 0;
    select(0);
    for (int i = 0; i < 68; i++) w_arr[i] = '0;
    for (int i = 0; i < 64; i++) wp_arr[i] = '0;
    @(negedge clk);
    test_reset();
    test_abc_latency();
    test_two_block_rpc();
    test_backpressure();
    test_input_gaps();
    test_back_to_back();
    test_lst_non_final();
    test_mid_reset();
`ifdef SM3_CMPRSS_MID_DGST_EN
    test_mid_dgst();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
